// File: rtl/meas_window_ctrl.sv
// Measurement-window sequencer: arms on the LFSR cycle marker, clears, accumulates 2^L symbols, dumps.
// Optional back-to-back windows via `define MEAS_WIN_CONTINUOUS_EN (adds the cont input).
module meas_window_ctrl #(
    parameter int unsigned MAX_LOG2    = 20,
    parameter int unsigned ARM_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sym_clk_en,
    input  logic                start,
    input  logic                abort,
    input  logic                cycle_marker,
    input  logic [4:0]          win_log2,
`ifdef MEAS_WIN_CONTINUOUS_EN
    input  logic                cont,
`endif
    output logic                acc_clr,
    output logic                acc_en,
    output logic                acc_dump,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [MAX_LOG2-1:0] sym_count
);

    localparam int unsigned W_CNT = MAX_LOG2 + 1;
    localparam int unsigned W_ARM = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
    localparam logic [4:0]       LEN_MAX  = 5'(MAX_LOG2);
    localparam logic [W_ARM-1:0] ARM_LAST = W_ARM'(ARM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CLEAR,
        S_RUN,
        S_DUMP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_len;
    logic [W_CNT-1:0] r_cnt;
    logic [W_ARM-1:0] r_arm_cnt;
    logic             r_timeout;

    logic             w_accept;
    logic             w_arm_inc;
    logic             w_expire;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_last;
    logic             w_cont;

`ifdef MEAS_WIN_CONTINUOUS_EN
    assign w_cont = cont;
`else
    assign w_cont = 1'b0;
`endif

    // Count value whose enable completes the window (2^L - 1 before increment)
    assign w_last = (r_cnt == ((W_CNT'(1) << r_len) - W_CNT'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort overrides every other transition, including timeout and window completion
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_arm_inc   = 1'b0;
        w_expire    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_ARM;
                        w_accept    = 1'b1;
                    end
                end
                S_ARM: begin
                    if (sym_clk_en) begin
                        if (cycle_marker) begin
                            w_state_nxt = S_CLEAR;
                        end else if (r_arm_cnt == ARM_LAST) begin
                            w_state_nxt = S_IDLE;
                            w_expire    = 1'b1;
                        end else begin
                            w_arm_inc = 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    w_state_nxt = S_RUN;
                    w_cnt_clr   = 1'b1;
                end
                S_RUN: begin
                    if (sym_clk_en) begin
                        w_cnt_inc = 1'b1;
                        if (w_last) begin
                            w_state_nxt = S_DUMP;
                        end
                    end
                end
                S_DUMP: begin
                    w_state_nxt = w_cont ? S_CLEAR : S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Window length, arm counter, sticky timeout and symbol counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len     <= 5'd0;
            r_cnt     <= '0;
            r_arm_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len     <= (win_log2 > LEN_MAX) ? LEN_MAX : win_log2;
                r_timeout <= 1'b0;
                r_arm_cnt <= '0;
            end else if (w_arm_inc) begin
                r_arm_cnt <= r_arm_cnt + W_ARM'(1);
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc && (r_cnt != {W_CNT{1'b1}})) begin
                r_cnt <= r_cnt + W_CNT'(1);
            end
        end
    end

    assign acc_clr   = (r_state == S_CLEAR);
    assign acc_en    = (r_state == S_RUN) && sym_clk_en;
    assign acc_dump  = (r_state == S_DUMP);
    assign done      = (r_state == S_DUMP);
    assign busy      = (r_state != S_IDLE);
    assign timeout   = r_timeout;
    assign sym_count = r_cnt[MAX_LOG2-1:0];

endmodule

// File: tb/tb_meas_window_ctrl.sv
// Bench for meas_window_ctrl: per-cycle compare against a window model plus directed literal checks.
module tb_meas_window_ctrl;

    localparam int unsigned MAXL = 4;
    localparam int unsigned ATO  = 16;

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_CLEAR = 2;
    localparam int P_RUN   = 3;
    localparam int P_DUMP  = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            sym_clk_en = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            cycle_marker = 1'b0;
    logic [4:0]      win_log2 = 5'd0;
    logic            cont = 1'b0;
    logic            acc_clr, acc_en, acc_dump, busy, done, timeout;
    logic [MAXL-1:0] sym_count;

    int total = 0;
    int bad = 0;
    int en_seen = 0;
    int done_seen = 0;

    int m_phase = P_IDLE;
    int m_len = 0;
    int m_cnt = 0;
    int m_rem = 0;
    int m_waited = 0;
    bit m_to = 1'b0;

    meas_window_ctrl #(.MAX_LOG2(MAXL), .ARM_TIMEOUT(ATO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sym_clk_en   (sym_clk_en),
        .start        (start),
        .abort        (abort),
        .cycle_marker (cycle_marker),
        .win_log2     (win_log2),
`ifdef MEAS_WIN_CONTINUOUS_EN
        .cont         (cont),
`endif
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .acc_dump     (acc_dump),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .sym_count    (sym_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Window model: remaining-symbol countdown, strobes waited for the marker
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = P_IDLE; m_len = 0; m_cnt = 0; m_rem = 0; m_waited = 0; m_to = 1'b0;
        end else if (m_phase == P_IDLE) begin
            if (start && !abort) begin
                m_len = (int'(win_log2) > int'(MAXL)) ? int'(MAXL) : int'(win_log2);
                m_to = 1'b0; m_waited = 0; m_phase = P_WAIT;
            end
        end else if (abort) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_WAIT: if (sym_clk_en) begin
                    if (cycle_marker) m_phase = P_CLEAR;
                    else begin
                        m_waited++;
                        if (m_waited == int'(ATO)) begin m_phase = P_IDLE; m_to = 1'b1; end
                    end
                end
                P_CLEAR: begin m_cnt = 0; m_rem = 1 << m_len; m_phase = P_RUN; end
                P_RUN: if (sym_clk_en) begin
                    m_cnt++; m_rem--;
                    if (m_rem == 0) m_phase = P_DUMP;
                end
                default: m_phase = cont ? P_CLEAR : P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        check("acc_clr",   int'(acc_clr),   int'(m_phase == P_CLEAR));
        check("acc_en",    int'(acc_en),    int'(m_phase == P_RUN && sym_clk_en));
        check("acc_dump",  int'(acc_dump),  int'(m_phase == P_DUMP));
        check("done",      int'(done),      int'(m_phase == P_DUMP));
        check("busy",      int'(busy),      int'(m_phase != P_IDLE));
        check("timeout",   int'(timeout),   int'(m_to));
        check("sym_count", int'(sym_count), m_cnt % (1 << MAXL));
        if (acc_en) en_seen++;
        if (done) done_seen++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sym(input bit mk);
        sym_clk_en = 1'b1; cycle_marker = mk;
        tick();
        sym_clk_en = 1'b0; cycle_marker = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] l);
        win_log2 = l; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int en0, d0;

    initial begin
        // Reset held for 3 clocks, then 10 quiet clocks
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_busy", int'(busy), 0);
        end

        // Basic window: 32-clock symbols, L=3, marker on 5th symbol
        en0 = en_seen;
        pulse_start(5'd3);
        for (int i = 0; i < 4; i++) begin sym(1'b0); idle(31); end
        sym(1'b1);
        check("t2_clr", int'(acc_clr), 1);
        idle(31);
        for (int i = 0; i < 8; i++) begin
            sym(1'b0);
            if (i < 7) idle(31);
        end
        check("t2_done", int'(done), 1);
        check("t2_dump", int'(acc_dump), 1);
        check("t2_count", int'(sym_count), 8);
        check("t2_en_pulses", en_seen - en0, 8);
        tick();
        check("t2_busy_drop", int'(busy), 0);

        // Timeout: no marker for 16 strobes
        pulse_start(5'd3);
        for (int i = 1; i <= 16; i++) begin
            sym(1'b0);
            if (i == 15) check("t3_busy15", int'(busy), 1);
            if (i == 16) begin
                check("t3_idle16", int'(busy), 0);
                check("t3_to_set", int'(timeout), 1);
            end
            idle(1);
        end
        idle(5);
        check("t3_to_sticky", int'(timeout), 1);
        pulse_start(5'd3);
        check("t3_to_clear", int'(timeout), 0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t3_abort_arm", int'(busy), 0);

        // Abort in RUN at sym_count=5
        d0 = done_seen;
        pulse_start(5'd4);
        sym(1'b1);
        tick();
        repeat (5) begin sym(1'b0); idle(1); end
        check("t4_count5", int'(sym_count), 5);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t4_idle", int'(busy), 0);
        check("t4_keep", int'(sym_count), 5);
        idle(3);
        check("t4_no_done", done_seen - d0, 0);

        // L=0: one symbol then dump
        pulse_start(5'd0);
        sym(1'b1);
        tick();
        sym(1'b0);
        check("l0_done", int'(done), 1);
        check("l0_count", int'(sym_count), 1);
        tick();

        // Abort coincident with the completing strobe
        d0 = done_seen;
        pulse_start(5'd0);
        sym(1'b1);
        tick();
        sym_clk_en = 1'b1; abort = 1'b1;
        tick();
        sym_clk_en = 1'b0; abort = 1'b0;
        check("ab_last_idle", int'(busy), 0);
        idle(2);
        check("ab_last_nodone", done_seen - d0, 0);

        // start and abort together in IDLE
        win_log2 = 5'd1; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_idle", int'(busy), 0);

        // Clamp 31 -> 4, starts and length changes during the window ignored
        en0 = en_seen;
        pulse_start(5'd31);
        win_log2 = 5'd0;
        sym(1'b1);
        tick();
        for (int i = 0; i < 16; i++) begin
            sym(1'b0);
            if (i < 15) begin start = 1'b1; tick(); start = 1'b0; end
        end
        check("t5_done", int'(done), 1);
        check("t5_fullscale", int'(sym_count), 0);
        check("t5_en_pulses", en_seen - en0, 16);
        tick();
        check("t5_idle", int'(busy), 0);

`ifdef MEAS_WIN_CONTINUOUS_EN
        // Continuous windows: marker honoured only once
        cont = 1'b1;
        pulse_start(5'd2);
        sym(1'b1);
        tick();
        en0 = en_seen; d0 = done_seen;
        for (int i = 0; i < 12; i++) begin
            if (i == 11) cont = 1'b0;
            sym(1'b1);
            idle(3);
        end
        check("t6_idle", int'(busy), 0);
        check("t6_en_pulses", en_seen - en0, 12);
        check("t6_dones", done_seen - d0, 3);
`endif

        // Reset mid-window
        d0 = done_seen;
        pulse_start(5'd2);
        sym(1'b1);
        tick();
        sym(1'b0);
        reset_n = 1'b0;
        #1;
        check("mr_busy", int'(busy), 0);
        check("mr_count", int'(sym_count), 0);
        tick();
        reset_n = 1'b1;
        idle(3);
        check("mr_stay_idle", int'(busy), 0);
        check("mr_no_done", done_seen - d0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
